// File: rtl/boot_copier.sv
// boot_copier: copies COPY_WORDS words from the boot ROM into RAM, then releases the CPU reset.
module boot_copier #(
  parameter int BITS             = 32,
  parameter int ROM_ADDRESS_BITS = 10,
  parameter int RAM_ADDRESS_BITS = 12,
  parameter int COPY_WORDS       = 1024,
  parameter int RAM_BASE         = 0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  output logic [ROM_ADDRESS_BITS-1:0] rom_addr,
  input  logic [BITS-1:0]             rom_data,
  input  logic                        rom_data_valid,
  output logic [RAM_ADDRESS_BITS-1:0] ram_addr,
  output logic [BITS-1:0]             ram_wdata,
  output logic                        ram_we,
  input  logic                        ram_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        cpu_rst
);
  localparam int CW = ROM_ADDRESS_BITS + 1;
  localparam logic [CW-1:0] LAST = CW'((COPY_WORDS > 0) ? COPY_WORDS - 1 : 0);
  localparam logic [RAM_ADDRESS_BITS-1:0] BASE = RAM_ADDRESS_BITS'(RAM_BASE);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, WRITE, DONE} state_t;
  state_t                      r_state, w_state;
  logic [ROM_ADDRESS_BITS-1:0] r_rom_addr, w_rom_addr;
  logic [RAM_ADDRESS_BITS-1:0] r_ram_addr, w_ram_addr;
  logic [BITS-1:0]             r_wdata, w_wdata;
  logic [CW-1:0]               r_cnt, w_cnt;
  logic                        r_we, r_busy, r_done, r_cpu_rst;
  always_comb begin
    w_state    = r_state;
    w_rom_addr = r_rom_addr;
    w_ram_addr = r_ram_addr;
    w_wdata    = r_wdata;
    w_cnt      = r_cnt;
    case (r_state)
      IDLE:  if (start) w_state = (COPY_WORDS > 0) ? ADDR : DONE;
      ADDR:  w_state = WAIT;
      WAIT:  if (rom_data_valid) begin
        w_state = WRITE;
        w_wdata = rom_data;
      end
      WRITE: if (ram_ready) begin
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == LAST) w_state = DONE;
        else begin
          w_state    = ADDR;
          w_rom_addr = r_rom_addr + 1'b1;
          w_ram_addr = r_ram_addr + 1'b1;
        end
      end
      DONE:  w_state = DONE;
      default: w_state = IDLE;
    endcase
  end
  // Status outputs are registered from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_rom_addr <= '0;
      r_ram_addr <= BASE;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cpu_rst  <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_rom_addr <= w_rom_addr;
      r_ram_addr <= w_ram_addr;
      r_wdata    <= w_wdata;
      r_cnt      <= w_cnt;
      r_we       <= w_state == WRITE;
      r_busy     <= w_state == ADDR || w_state == WAIT || w_state == WRITE;
      r_done     <= w_state == DONE;
      r_cpu_rst  <= w_state != DONE;
    end
  end
  assign rom_addr  = r_rom_addr;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_wdata;
  assign ram_we    = r_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cpu_rst   = r_cpu_rst;
endmodule
